// File: rtl/store_merge_ctrl.sv
// store_merge_ctrl: read-modify-write sequencer for one 256-bit data-array line.
// A single 32-bit byte-enabled store is merged into the line.
//
// The line is read, then passed through an external merge datapath (mg_*).
// The merged result is captured and written back. The array port is used
// only in cycles where arr_gnt is high.
//
// Optional feature (macro STORE_COALESCE_EN):
//   While the write is pending, a new store to the same line is folded into
//   the line being written. A store to a different line is parked in a
//   one-entry slot and issued straight after the write.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   st_valid/st_ready store handshake
//   st_addr           store byte address ([4:2] word select, [1:0] ignored)
//   st_wd, st_be      store data and byte enables
//   arr_gnt           array port granted this cycle
//   arr_rd_en         array read request
//   arr_wr_en         array write request
//   arr_idx           array line index
//   arr_rd_data       array read data (one cycle after a granted read)
//   arr_wr_data       merged line to write
//   mg_rd             merge datapath: line input
//   mg_wd, mg_be      merge datapath: store data and byte enables
//   mg_sel            merge datapath: word select
//   mg_y              merge datapath result
//   busy              store in flight
module store_merge_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_wd,
  input  logic [3:0]        st_be,
  input  logic              arr_gnt,
  output logic              arr_rd_en,
  output logic              arr_wr_en,
  output logic [ADDR_W-6:0] arr_idx,
  input  logic [255:0]      arr_rd_data,
  output logic [255:0]      arr_wr_data,
  output logic [255:0]      mg_rd,
  output logic [31:0]       mg_wd,
  output logic [3:0]        mg_be,
  output logic [2:0]        mg_sel,
  input  logic [255:0]      mg_y,
  output logic              busy
);

  localparam int IDX_W = ADDR_W - 5;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_WR} state_t;

  state_t             state;
  state_t             state_nx;
  logic [IDX_W-1:0]   idx_q;
  logic [2:0]         sel_q;
  logic [31:0]        wd_q;
  logic [3:0]         be_q;
  logic [255:0]       line_q;
  logic               xfer;
  logic               new_st;
  logic               unused_addr_lsb;

  // Byte offset within the word is irrelevant to a word-granular merge.
  assign unused_addr_lsb = ^st_addr[1:0];

`ifdef STORE_COALESCE_EN
  logic               pend_v;
  logic [IDX_W-1:0]   pend_idx;
  logic [2:0]         pend_sel;
  logic [31:0]        pend_wd;
  logic [3:0]         pend_be;
  logic               coal;
  logic               wr_fire;

  assign st_ready = (state == S_IDLE) || ((state == S_WR) && !pend_v);
  assign busy     = (state != S_IDLE) || pend_v;
`else
  assign st_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
`endif

  assign xfer        = st_valid && st_ready;
  // Zero-byte stores are accepted but never start an array access.
  assign new_st      = xfer && (st_be != 4'b0000);
  assign arr_idx     = idx_q;
  assign arr_wr_data = line_q;

`ifdef STORE_COALESCE_EN
  // Same-line store during WR: merge into line_q instead of writing this cycle.
  assign coal    = (state == S_WR) && new_st && (st_addr[ADDR_W-1:5] == idx_q);
  assign wr_fire = (state == S_WR) && !coal && arr_gnt;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state, array requests and merge datapath steering
  always_comb begin
    state_nx  = state;
    arr_rd_en = 1'b0;
    arr_wr_en = 1'b0;
    mg_rd     = 256'd0;
    mg_wd     = wd_q;
    mg_be     = be_q;
    mg_sel    = sel_q;
    case (state)
      S_IDLE: begin
        if (new_st) state_nx = S_RD;
        else        state_nx = S_IDLE;
      end
      S_RD: begin
        arr_rd_en = 1'b1;
        if (arr_gnt) state_nx = S_WAIT;
        else         state_nx = S_RD;
      end
      S_WAIT: begin
        mg_rd    = arr_rd_data;
        state_nx = S_WR;
      end
      S_WR: begin
`ifdef STORE_COALESCE_EN
        if (coal) begin
          mg_rd    = line_q;
          mg_wd    = st_wd;
          mg_be    = st_be;
          mg_sel   = st_addr[4:2];
          state_nx = S_WR;
        end else begin
          arr_wr_en = 1'b1;
          // After the write, a parked or just-arrived different-line store
          // goes straight to RD.
          if (arr_gnt) begin
            if (pend_v || new_st) state_nx = S_RD;
            else                  state_nx = S_IDLE;
          end else begin
            state_nx = S_WR;
          end
        end
`else
        arr_wr_en = 1'b1;
        if (arr_gnt) state_nx = S_IDLE;
        else         state_nx = S_WR;
`endif
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Capture registers for the store being processed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= {IDX_W{1'b0}};
      sel_q <= 3'd0;
      wd_q  <= 32'd0;
      be_q  <= 4'd0;
    end else if ((state == S_IDLE) && xfer) begin
      idx_q <= st_addr[ADDR_W-1:5];
      sel_q <= st_addr[4:2];
      wd_q  <= st_wd;
      be_q  <= st_be;
`ifdef STORE_COALESCE_EN
    end else if (wr_fire && pend_v) begin
      idx_q <= pend_idx;
      sel_q <= pend_sel;
      wd_q  <= pend_wd;
      be_q  <= pend_be;
    end else if (wr_fire && new_st) begin
      idx_q <= st_addr[ADDR_W-1:5];
      sel_q <= st_addr[4:2];
      wd_q  <= st_wd;
      be_q  <= st_be;
`endif
    end
  end

  // Merged line capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q <= 256'd0;
    end else if (state == S_WAIT) begin
      line_q <= mg_y;
`ifdef STORE_COALESCE_EN
    end else if (coal) begin
      line_q <= mg_y;
`endif
    end
  end

`ifdef STORE_COALESCE_EN
  // One-entry pending slot for a different-line store arriving during WR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_v   <= 1'b0;
      pend_idx <= {IDX_W{1'b0}};
      pend_sel <= 3'd0;
      pend_wd  <= 32'd0;
      pend_be  <= 4'd0;
    end else if (wr_fire && pend_v) begin
      pend_v <= 1'b0;
    end else if ((state == S_WR) && new_st && !coal && !arr_gnt) begin
      pend_v   <= 1'b1;
      pend_idx <= st_addr[ADDR_W-1:5];
      pend_sel <= st_addr[4:2];
      pend_wd  <= st_wd;
      pend_be  <= st_be;
    end
  end
`endif

endmodule

// File: tb/tb_store_merge_ctrl.sv
// Self-checking bench for store_merge_ctrl: directed stores against a simple
// array model and a behavioural merge datapath.
module tb_store_merge_ctrl;

  logic         clk;
  logic         reset;
  logic         st_valid;
  logic         st_ready;
  logic [31:0]  st_addr;
  logic [31:0]  st_wd;
  logic [3:0]   st_be;
  logic         arr_gnt;
  logic         arr_rd_en;
  logic         arr_wr_en;
  logic [26:0]  arr_idx;
  logic [255:0] arr_rd_data;
  logic [255:0] arr_wr_data;
  logic [255:0] mg_rd;
  logic [31:0]  mg_wd;
  logic [3:0]   mg_be;
  logic [2:0]   mg_sel;
  logic [255:0] mg_y;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [255:0] line_pat;
  int           rd_cnt = 0;
  int           wr_cnt = 0;
  logic [255:0] last_wr_data;
  logic [26:0]  last_wr_idx;

  store_merge_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_wd(st_wd), .st_be(st_be), .arr_gnt(arr_gnt),
    .arr_rd_en(arr_rd_en), .arr_wr_en(arr_wr_en), .arr_idx(arr_idx),
    .arr_rd_data(arr_rd_data), .arr_wr_data(arr_wr_data), .mg_rd(mg_rd),
    .mg_wd(mg_wd), .mg_be(mg_be), .mg_sel(mg_sel), .mg_y(mg_y), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] merge(input logic [255:0] rd, input logic [31:0] wd,
                                         input logic [3:0] be, input logic [2:0] sel);
    logic [255:0] y;
    y = rd;
    for (int b = 0; b < 4; b++)
      if (be[b]) y[sel*32 + b*8 +: 8] = wd[b*8 +: 8];
    return y;
  endfunction

  assign mg_y = merge(mg_rd, mg_wd, mg_be, mg_sel);

  // Array model: read data one cycle after a granted read, log granted writes.
  always @(posedge clk) begin
    if (arr_rd_en && arr_gnt) begin
      arr_rd_data <= line_pat;
      rd_cnt      <= rd_cnt + 1;
    end
    if (arr_wr_en && arr_gnt) begin
      last_wr_data <= arr_wr_data;
      last_wr_idx  <= arr_idx;
      wr_cnt       <= wr_cnt + 1;
    end
  end

  task automatic test_reset();
    reset = 1'b1; st_valid = 1'b0; st_addr = 32'd0; st_wd = 32'd0; st_be = 4'd0;
    arr_gnt = 1'b0; line_pat = 256'd0; arr_rd_data = 256'd0;
    repeat (2) @(negedge clk);
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got %b exp 1", st_ready); end
    checks++; if ({arr_rd_en, arr_wr_en, busy} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b exp 000", {arr_rd_en, arr_wr_en, busy}); end
    checks++; if (arr_idx !== 27'd0) begin errors++; $display("FAIL reset_idx got %h exp 0", arr_idx); end
    checks++; if (arr_wr_data !== 256'd0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", arr_wr_data); end
    reset = 1'b0;
  endtask

  task automatic test_full_word();
    int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    @(negedge clk);
    line_pat = {8{32'h11111111}};
    st_valid = 1'b1; st_addr = 32'h0000_0048; st_wd = 32'hDEADBEEF; st_be = 4'b1111; arr_gnt = 1'b1;
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL fw_accept got %b exp 1", st_ready); end
    @(negedge clk);
    st_valid = 1'b0;
    checks++; if ({arr_rd_en, arr_wr_en} !== 2'b10) begin errors++; $display("FAIL fw_rd got %b exp 10", {arr_rd_en, arr_wr_en}); end
    checks++; if (arr_idx !== 27'd2) begin errors++; $display("FAIL fw_idx got %h exp 2", arr_idx); end
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL fw_ready_rd got %b exp 0", st_ready); end
    @(negedge clk);
    checks++; if ({arr_rd_en, arr_wr_en} !== 2'b00) begin errors++; $display("FAIL fw_wait got %b exp 00", {arr_rd_en, arr_wr_en}); end
    checks++; if (mg_rd !== {8{32'h11111111}}) begin errors++; $display("FAIL fw_mg_rd got %h exp all 11", mg_rd); end
    @(negedge clk);
    checks++; if ({arr_rd_en, arr_wr_en} !== 2'b01) begin errors++; $display("FAIL fw_wr got %b exp 01", {arr_rd_en, arr_wr_en}); end
    checks++; if (arr_wr_data !== 256'h11111111_11111111_11111111_11111111_11111111_DEADBEEF_11111111_11111111) begin
      errors++; $display("FAIL fw_wr_data got %h", arr_wr_data); end
    @(negedge clk);
    checks++; if ({busy, st_ready} !== 2'b01) begin errors++; $display("FAIL fw_idle got %b exp 01", {busy, st_ready}); end
    checks++; if ((rd_cnt - r0) != 1 || (wr_cnt - w0) != 1 || last_wr_idx !== 27'd2) begin
      errors++; $display("FAIL fw_counts rd %0d wr %0d idx %h exp 1 1 2", rd_cnt - r0, wr_cnt - w0, last_wr_idx); end
  endtask

  task automatic test_partial_bytes();
    @(negedge clk);
    line_pat = {32'h12345678, 224'd0};
    st_valid = 1'b1; st_addr = 32'h0000_007C; st_wd = 32'hAABBCCDD; st_be = 4'b0101; arr_gnt = 1'b1;
    @(negedge clk);
    st_valid = 1'b0;
    checks++; if (arr_idx !== 27'd3 || mg_sel !== 3'd7 || mg_be !== 4'b0101) begin
      errors++; $display("FAIL pb_capture got idx %h sel %0d be %b exp 3 7 0101", arr_idx, mg_sel, mg_be); end
    repeat (2) @(negedge clk);
    checks++; if (arr_wr_en !== 1'b1 || arr_wr_data !== {32'h12BB56DD, 224'd0}) begin
      errors++; $display("FAIL pb_wr_data got en %b data %h exp word7 12bb56dd", arr_wr_en, arr_wr_data); end
    @(negedge clk);
  endtask

  task automatic test_grant_stall();
    int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    @(negedge clk);
    line_pat = 256'd0;
    st_valid = 1'b1; st_addr = 32'h0000_0040; st_wd = 32'h01020304; st_be = 4'b1111; arr_gnt = 1'b0;
    @(negedge clk);
    st_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({arr_rd_en, arr_wr_en, st_ready, busy} !== 4'b1001 || arr_idx !== 27'd2) begin
        errors++; $display("FAIL gs_rd_hold cyc %0d got %b idx %h exp 1001 2", i, {arr_rd_en, arr_wr_en, st_ready, busy}, arr_idx); end
      @(negedge clk);
    end
    arr_gnt = 1'b1;
    @(negedge clk);
    arr_gnt = 1'b0;
    checks++; if ({arr_rd_en, arr_wr_en, st_ready, busy} !== 4'b0001) begin
      errors++; $display("FAIL gs_wait got %b exp 0001", {arr_rd_en, arr_wr_en, st_ready, busy}); end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
`ifdef STORE_COALESCE_EN
      checks++; if ({arr_rd_en, arr_wr_en, st_ready, busy} !== 4'b0111) begin
        errors++; $display("FAIL gs_wr_hold cyc %0d got %b exp 0111", i, {arr_rd_en, arr_wr_en, st_ready, busy}); end
`else
      checks++; if ({arr_rd_en, arr_wr_en, st_ready, busy} !== 4'b0101) begin
        errors++; $display("FAIL gs_wr_hold cyc %0d got %b exp 0101", i, {arr_rd_en, arr_wr_en, st_ready, busy}); end
`endif
      @(negedge clk);
    end
    arr_gnt = 1'b1;
    @(negedge clk);
    checks++; if ((rd_cnt - r0) != 1 || (wr_cnt - w0) != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL gs_counts rd %0d wr %0d busy %b exp 1 1 0", rd_cnt - r0, wr_cnt - w0, busy); end
  endtask

  task automatic test_zero_be();
    int r0;
    r0 = rd_cnt;
    @(negedge clk);
    line_pat = {8{32'hFFFFFFFF}};
    st_valid = 1'b1; st_addr = 32'h0000_0020; st_wd = 32'h55555555; st_be = 4'b0000; arr_gnt = 1'b1;
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL zb_accept got %b exp 1", st_ready); end
    @(negedge clk);
    checks++; if ({arr_rd_en, arr_wr_en, busy} !== 3'b000) begin
      errors++; $display("FAIL zb_no_access got %b exp 000", {arr_rd_en, arr_wr_en, busy}); end
    st_addr = 32'h0000_0024; st_wd = 32'h0000BEEF; st_be = 4'b0011;
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL zb_next_ready got %b exp 1", st_ready); end
    @(negedge clk);
    st_valid = 1'b0;
    checks++; if (arr_rd_en !== 1'b1 || arr_idx !== 27'd1 || mg_sel !== 3'd1 || rd_cnt != r0) begin
      errors++; $display("FAIL zb_next_rd got en %b idx %h sel %0d reads %0d exp 1 1 1 0", arr_rd_en, arr_idx, mg_sel, rd_cnt - r0); end
    repeat (2) @(negedge clk);
    checks++; if (arr_wr_data !== 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFBEEF_FFFFFFFF) begin
      errors++; $display("FAIL zb_wr_data got %h", arr_wr_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    int w0;
    @(negedge clk);
    line_pat = {8{32'h0F0F0F0F}};
    st_valid = 1'b1; st_addr = 32'h0000_0060; st_wd = 32'h12345678; st_be = 4'b1111; arr_gnt = 1'b1;
    @(negedge clk);
    st_valid = 1'b0;
    @(negedge clk);
    w0 = wr_cnt;
    reset = 1'b1;
    #1;
    checks++; if ({st_ready, arr_rd_en, arr_wr_en, busy} !== 4'b1000) begin
      errors++; $display("FAIL rw_ctrl got %b exp 1000", {st_ready, arr_rd_en, arr_wr_en, busy}); end
    checks++; if (arr_idx !== 27'd0 || arr_wr_data !== 256'd0 || mg_rd !== 256'd0) begin
      errors++; $display("FAIL rw_data got idx %h wd %h exp 0", arr_idx, arr_wr_data); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (wr_cnt != w0 || busy !== 1'b0) begin
      errors++; $display("FAIL rw_no_write got writes %0d busy %b exp 0 0", wr_cnt - w0, busy); end
  endtask

`ifdef STORE_COALESCE_EN
  task automatic test_coalesce();
    int w0;
    @(negedge clk);
    line_pat = 256'd0;
    st_valid = 1'b1; st_addr = 32'h0000_0080; st_wd = 32'hA0A0A0A0; st_be = 4'b1111; arr_gnt = 1'b1;
    @(negedge clk);
    st_valid = 1'b0;
    @(negedge clk);
    arr_gnt = 1'b0;
    @(negedge clk);
    checks++; if (arr_wr_en !== 1'b1 || st_ready !== 1'b1) begin
      errors++; $display("FAIL co_wr got en %b ready %b exp 1 1", arr_wr_en, st_ready); end
    st_valid = 1'b1; st_addr = 32'h0000_0084; st_wd = 32'hB1B1B1B1; st_be = 4'b1111;
    #1;
    checks++; if (arr_wr_en !== 1'b0 || mg_sel !== 3'd1 || mg_rd !== {224'd0, 32'hA0A0A0A0}) begin
      errors++; $display("FAIL co_merge got en %b sel %0d rd %h", arr_wr_en, mg_sel, mg_rd); end
    @(negedge clk);
    st_addr = 32'h0000_00A0; st_wd = 32'hC3C3C3C3;
    #1;
    checks++; if (arr_wr_en !== 1'b1 || st_ready !== 1'b1) begin
      errors++; $display("FAIL co_park got en %b ready %b exp 1 1", arr_wr_en, st_ready); end
    @(negedge clk);
    st_valid = 1'b0;
    checks++; if ({st_ready, busy, arr_wr_en} !== 3'b011) begin
      errors++; $display("FAIL co_pend got %b exp 011", {st_ready, busy, arr_wr_en}); end
    w0 = wr_cnt;
    arr_gnt = 1'b1;
    @(negedge clk);
    checks++; if (wr_cnt != w0 + 1 || last_wr_idx !== 27'd4 || last_wr_data !== {192'd0, 32'hB1B1B1B1, 32'hA0A0A0A0}) begin
      errors++; $display("FAIL co_write got n %0d idx %h data %h", wr_cnt - w0, last_wr_idx, last_wr_data); end
    checks++; if (arr_rd_en !== 1'b1 || arr_idx !== 27'd5 || mg_sel !== 3'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL co_next_rd got en %b idx %h sel %0d busy %b exp 1 5 0 1", arr_rd_en, arr_idx, mg_sel, busy); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || last_wr_data !== {224'd0, 32'hC3C3C3C3}) begin
      errors++; $display("FAIL co_second got busy %b data %h", busy, last_wr_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_word();
    test_partial_bytes();
    test_grant_stall();
    test_zero_be();
    test_reset_in_wait();
`ifdef STORE_COALESCE_EN
    test_coalesce();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
